// File: rtl/wb_sram_responder.sv
// Wishbone B4 pipelined slave backed by a word-organised SRAM.
// Fixed-latency ack/err with an outstanding-response budget that drives stall.
module wb_sram_responder #(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]        r_mem [DEPTH];
  logic [CNT_W-1:0]   r_cnt;
  logic [LATENCY-1:0] r_vld_p;
  logic [LATENCY-1:0] r_err_p;
  logic [31:0]        r_dat_p [LATENCY];

  logic          w_accept;
  logic          w_in_range;
  logic          w_rsp;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_dat;
  logic          w_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // adr[1:0] only selects a byte inside the word and has no effect here
  assign w_unused   = &{1'b0, adr[1:0]};
  assign w_in_range = (adr[31:2] < 30'(DEPTH));
  assign w_idx      = adr[AW+1:2];
  assign w_accept   = cyc && stb && !stall && !rst;
  assign w_rsp      = r_vld_p[LATENCY-1];
  assign w_rd_dat   = (!we && w_in_range) ? r_mem[w_idx] : '0;

  always_ff @(posedge clk) begin
    if (w_accept && we && w_in_range) begin
      r_mem[w_idx] <= merge_bytes(r_mem[w_idx], dat_i, sel);
    end
  end

  // Stage boundary: accept edge loads p[0], each later edge shifts one stage
  always_ff @(posedge clk) begin
    r_dat_p[0] <= w_rd_dat;
    for (int i = 1; i < LATENCY; i++) begin
      r_dat_p[i] <= r_dat_p[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p <= '0;
      r_err_p <= '0;
      r_cnt   <= '0;
    end else if (!cyc) begin
      // Master abandoned the cycle: drop every pending response
      r_vld_p <= '0;
      r_cnt   <= '0;
    end else begin
      r_vld_p[0] <= w_accept;
      r_err_p[0] <= !w_in_range;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_err_p[i] <= r_err_p[i-1];
      end
      if (w_accept && !w_rsp) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_accept && w_rsp) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Output stage: last pipeline entry drives the bus
  assign ack   = r_vld_p[LATENCY-1] && !r_err_p[LATENCY-1];
  assign err   = r_vld_p[LATENCY-1] &&  r_err_p[LATENCY-1];
  assign dat_o = ack ? r_dat_p[LATENCY-1] : '0;
  assign stall = (r_cnt == MAX_CNT);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(ack && err));
      assert (r_cnt <= MAX_CNT);
      if (ack || err) assert (r_cnt != '0);
    end
  end
`endif

endmodule
